// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the program counter and issues one word read at a
// time to instruction memory. Each fetched word and its PC are handed to decode
// through a valid/stall handshake. Execute can redirect the PC in any state,
// including while a read is still in flight.
//
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect
// targets into a sticky ERROR state. Without it, the low two target bits are
// forced to zero and fetch_error is tied low.
//
// state | meaning
// BOOT  | out of reset, no request yet
// FETCH | read request outstanding at pc
// HOLD  | fetched word presented to decode
// FLUSH | in-flight read will be discarded; pending holds the next pc
// ERROR | misaligned redirect trapped; idle until an aligned redirect
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_request,
    output logic [31:0] mem_address,
    input  logic        mem_ready,
    input  logic [31:0] mem_read_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    output logic        instruction_valid,
    output logic [31:0] instruction,
    output logic [31:0] instruction_pc,
    output logic        fetch_error
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        HOLD  = 3'd2,
        FLUSH = 3'd3,
        ERROR = 3'd4
    } state_t;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [31:0] TARGET_MASK = 32'hFFFF_FFFF;
    localparam logic [1:0]  TRAP_MASK   = 2'b11;
`else
    localparam logic [31:0] TARGET_MASK = 32'hFFFF_FFFC;
    localparam logic [1:0]  TRAP_MASK   = 2'b00;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;

    logic [31:0] target;
    logic        do_load;
    logic [31:0] load_addr;

    assign target = redirect_target & TARGET_MASK;

    // Next-state logic; any PC load from a redirect funnels through do_load so
    // the alignment check sits in one place.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        do_load    = 1'b0;
        load_addr  = target;

        case (state_q)
            BOOT: begin
                if (redirect_valid) begin
                    do_load = 1'b1;
                end else begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    if (mem_ready) begin
                        do_load = 1'b1;
                    end else begin
                        // address must stay put until the read completes
                        pending_d = target;
                        state_d   = FLUSH;
                    end
                end else if (mem_ready) begin
                    instr_d    = mem_read_data;
                    instr_pc_d = pc_q;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    do_load = 1'b1;
                end else if (!stall) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            FLUSH: begin
                if (mem_ready) begin
                    // a redirect arriving with the completion is the newest target
                    do_load   = 1'b1;
                    load_addr = redirect_valid ? target : pending_q;
                end else if (redirect_valid) begin
                    pending_d = target;
                end
            end
            ERROR: begin
                if (redirect_valid) begin
                    do_load = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (do_load) begin
            if ((load_addr[1:0] & TRAP_MASK) != 2'b00) begin
                state_d = ERROR;
            end else begin
                pc_d    = load_addr;
                state_d = FETCH;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pending_q  <= RESET_PC;
            instr_q    <= 32'd0;
            instr_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Handshake outputs decode registered state only, never an input.
    assign mem_request       = (state_q == FETCH) || (state_q == FLUSH);
    assign mem_address       = pc_q;
    assign instruction_valid = (state_q == HOLD);
    assign instruction       = instr_q;
    assign instruction_pc    = instr_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_error       = (state_q == ERROR);
`else
    assign fetch_error       = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        mem_request;
    logic [31:0] mem_address;
    logic        mem_ready;
    logic [31:0] mem_read_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic        instruction_valid;
    logic [31:0] instruction;
    logic [31:0] instruction_pc;
    logic        fetch_error;

    int n_total;
    int n_pass;

    instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_request       (mem_request),
        .mem_address       (mem_address),
        .mem_ready         (mem_ready),
        .mem_read_data     (mem_read_data),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .stall             (stall),
        .instruction_valid (instruction_valid),
        .instruction       (instruction),
        .instruction_pc    (instruction_pc),
        .fetch_error       (fetch_error)
    );

    // memory returns a word derived from the address being read
    assign mem_read_data = mem_address ^ KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, mem_request}, 32'd1);
        chk({tag, "_addr"}, mem_address, addr);
        chk({tag, "_valid"}, {31'd0, instruction_valid}, 32'd0);
    endtask

    task automatic chk_hold(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, instruction_valid}, 32'd1);
        chk({tag, "_req"}, {31'd0, mem_request}, 32'd0);
        chk({tag, "_ipc"}, instruction_pc, pc);
        chk({tag, "_instr"}, instruction, pc ^ KEY);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset = 1'b1;
        mem_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        stall = 1'b0;

        step();
        step();
        chk("rst_req", {31'd0, mem_request}, 32'd0);
        chk("rst_addr", mem_address, 32'h100);
        chk("rst_valid", {31'd0, instruction_valid}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_ipc", instruction_pc, 32'h100);
        chk("rst_err", {31'd0, fetch_error}, 32'd0);

        // zero-wait streaming
        reset = 1'b0;
        mem_ready = 1'b1;
        step(); chk_fetch("f100", 32'h100);
        step(); chk_hold("h100", 32'h100);
        step(); chk_fetch("f104", 32'h104);
        step(); chk_hold("h104", 32'h104);
        step(); chk_fetch("f108", 32'h108);

        // three wait cycles
        mem_ready = 1'b0;
        step(); chk_fetch("w1", 32'h108);
        step(); chk_fetch("w2", 32'h108);
        step(); chk_fetch("w3", 32'h108);
        mem_ready = 1'b1;
        stall = 1'b1;
        step(); chk_hold("h108", 32'h108);

        // stalled hold stays frozen
        for (int i = 0; i < 4; i++) begin
            step(); chk_hold("stall", 32'h108);
        end
        stall = 1'b0;
        mem_ready = 1'b0;
        step(); chk_fetch("f10c", 32'h10C);

        // redirect during a pending read goes through FLUSH
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        step(); chk_fetch("flush1", 32'h10C);
        redirect_valid = 1'b0;
        step(); chk_fetch("flush2", 32'h10C);
        mem_ready = 1'b1;
        step(); chk_fetch("f200", 32'h200);
        step(); chk_hold("h200", 32'h200);

        // redirect in HOLD with stall low wins over pc+4
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step(); chk_fetch("ffc", 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        step(); chk_hold("hffc", 32'hFFFF_FFFC);
        step(); chk_fetch("wrap", 32'h0);

        // redirect in FETCH with ready: data discarded, stay in FETCH
        redirect_valid = 1'b1;
        redirect_target = 32'h400;
        step(); chk_fetch("f400", 32'h400);
        redirect_valid = 1'b0;
        step(); chk_hold("h400", 32'h400);

        // misaligned redirect from HOLD
        redirect_valid = 1'b1;
        redirect_target = 32'h202;
        step();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_err", {31'd0, fetch_error}, 32'd1);
        chk("mis_req", {31'd0, mem_request}, 32'd0);
        chk("mis_valid", {31'd0, instruction_valid}, 32'd0);
        redirect_valid = 1'b0;
        step();
        chk("mis_sticky", {31'd0, fetch_error}, 32'd1);
        chk("mis_req2", {31'd0, mem_request}, 32'd0);
`else
        chk_fetch("mis", 32'h200);
        chk("mis_err", {31'd0, fetch_error}, 32'd0);
`endif
        redirect_valid = 1'b1;
        redirect_target = 32'h300;
        mem_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk_fetch("f300", 32'h300);
`else
        // from FETCH without ready this routes through FLUSH first
        chk_fetch("fl300", 32'h200);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk_fetch("f300", 32'h300);
`endif
        chk("clr_err", {31'd0, fetch_error}, 32'd0);

        // reset mid-read drops the request immediately
        step();
        chk("pre_rst_req", {31'd0, mem_request}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, mem_request}, 32'd0);
        chk("async_rst_addr", mem_address, 32'h100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
